spi_register_bank: RTL and testbench
====================================

Name: spi_register_bank

Overview:
- Register bank and receive-FIFO endpoint directly downstream of the SPI slave front end.
- Consumes the front end's address byte, write byte and per-byte read/write strobes, which are generated in the SPI clock domain.
- Returns a read byte for the front end to shift out.
- Holds control registers, a read-only ID/status area, and a byte FIFO that system logic fills and the SPI host drains.

Parameters:
- CHIP_ID, 8'hA5, value returned at address 0x00.
- NUM_REGS, 8, number of 8-bit RW control registers at 0x10..0x10+NUM_REGS-1 (1..16).
- FIFO_DEPTH, 16, receive FIFO depth in bytes (power of two, 2..256).

Ports:
- clock_in  input  1  system clock; frequency ≥ 4× SPI clock.
- reset_in  input  1  asynchronous, active-high reset.
- address_in  input  8  register address from the SPI front end; stable for the whole data phase.
- wr_data_in  input  8  write byte from the SPI front end; stable ≥ 1 SPI period after data_wr_en_in rises.
- data_wr_en_in  input  1  write strobe in the SPI domain, high for one SPI period.
- data_rd_en_in  input  1  read-consumed strobe in the SPI domain, high for one SPI period.
- rd_data_out  output  8  read byte for the front end; combinational from address and state.
- status_in  input  8  system status, readable at 0x01.
- ctrl_regs_out  output  NUM_REGS*8  RW register contents; register i occupies bits [8i+7:8i].
- wr_strobe_out  output  1  one-clock pulse per accepted RW-register write.
- wr_addr_out  output  8  address of the last accepted write.
- fifo_data_in  input  8  system-side FIFO push data.
- fifo_valid_in  input  1  push request.
- fifo_ready_out  output  1  FIFO not full.

Behaviour:
- Reset: async on reset_in high.
  - ctrl_regs_out = 0, wr_strobe_out = 0, wr_addr_out = 0.
  - FIFO empty; pointers = 0; underflow flag = 0.
  - fifo_ready_out = 1 (0 when the feature is out).
- Strobe sync: each of data_wr_en_in and data_rd_en_in goes through a 2-flop synchronizer plus a rising-edge detector, giving one clock_in pulse per strobe.
  - All synchronizer and edge-detector flops reset to 1, so a strobe already high at reset release produces no pulse.
- Write path: on the wr pulse, latch wr_data_in and address_in in the same cycle.
  - Pulse-to-latch latency ≤ 3 clock_in cycles.
  - 0x10..0x10+NUM_REGS-1: update that register; wr_strobe_out = 1 and wr_addr_out = address the next cycle.
  - 0x03: if data bit2 = 1, clear the underflow flag. No wr_strobe_out.
  - All other addresses: write ignored, no strobe.
  - Multi-byte bursts rewrite the same address, since the address is fixed per transaction.
- Read mux (combinational):
  - 0x00: CHIP_ID.
  - 0x01: status_in.
  - 0x02: FIFO level, saturating display at 0xFF.
  - 0x03: {5'b0, underflow, full, empty}.
  - 0x04: FIFO head, or 0x00 when empty.
  - 0x10+i: register i.
  - Anything else: 0x00.
- rd_data_out must settle within one SPI period of the address completing. This is met by design: no registers sit in the path, and state changes only on clock_in.
- Read-consumed: the rd pulse with address 0x04 pops the FIFO.
  - The front end has already loaded the head byte, so no byte is lost when the transaction ends.
  - Pop while empty: pointers unchanged, underflow set (sticky).
  - rd pulse at any other address: no effect.
- FIFO push: fifo_valid_in && fifo_ready_out.
  - fifo_ready_out = !full, combinational from the level.
- Simultaneous push and pop: both are evaluated against the pre-cycle state.
  - Not empty: level unchanged, head advances, tail written.
  - Empty: push succeeds; pop counts as underflow.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs equal.
- Reset mid-transaction: all state is cleared immediately; in-flight strobes are discarded.

Optional Feature:
- SPI_REG_RXFIFO_EN defined: FIFO, addresses 0x02–0x04 and the underflow flag exist as described.
- Undefined: no FIFO storage.
  - 0x02–0x04 read 0x00; writes to 0x03 are ignored.
  - fifo_ready_out tied to 0; fifo_data_in and fifo_valid_in are unused.
  - rd pulses have no effect.

Test Plan:
- Reset, then address 0x00 and 0x01 with status_in=0x3C -> rd_data_out = 0xA5, then 0x3C; ctrl_regs_out = 0; fifo_ready_out = 1.
- SPI write 0x5A to 0x12 (clock_in = 8× SPI clock) -> register 2 = 0x5A within 3 clock_in cycles of the strobe; one wr_strobe_out pulse with wr_addr_out = 0x12; other registers unchanged.
- Push 0x11, 0x22, 0x33, then a 3-byte read burst at 0x04 -> bytes 0x11, 0x22, 0x33 presented in order; level 3→0; 0x03 then reads 0x01.
- Fourth rd pulse at 0x04 while empty -> reads 0x00; 0x03 reads 0x05; write 0x04 to 0x03 -> 0x03 reads 0x01.
- Push 16 bytes -> fifo_ready_out = 0, 0x03 reads 0x02, a 17th push is ignored; simultaneous push+pop at full -> level stays 16.
- Assert reset_in while data_wr_en_in is high mid-burst and release with it still high -> no write occurs, no wr_strobe_out pulse, all state at reset values.

Source files
------------

// File: rtl/spi_register_bank.sv
// Register bank and receive-FIFO endpoint behind an SPI slave front end.
// Optional receive FIFO (addresses 0x02..0x04, underflow flag) enabled by SPI_REG_RXFIFO_EN.
module spi_register_bank #(
    parameter logic [7:0] CHIP_ID    = 8'hA5,
    parameter int         NUM_REGS   = 8,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [7:0]            address_in,
    input  logic [7:0]            wr_data_in,
    input  logic                  data_wr_en_in,
    input  logic                  data_rd_en_in,
    output logic [7:0]            rd_data_out,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] ctrl_regs_out,
    output logic                  wr_strobe_out,
    output logic [7:0]            wr_addr_out,
    input  logic [7:0]            fifo_data_in,
    input  logic                  fifo_valid_in,
    output logic                  fifo_ready_out
);

    localparam logic [7:0] REG_BASE = 8'h10;
    localparam logic [7:0] REG_LAST = 8'(16 + NUM_REGS - 1);

    // Bits: [0] first sync stage, [1] second stage, [2] previous value for edge detect.
    // Reset to all ones so a strobe already high at reset release gives no pulse.
    logic [2:0] wr_sync_q;
    logic       wr_pulse;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wr_sync_q <= 3'b111;
        end else begin
            wr_sync_q <= {wr_sync_q[1:0], data_wr_en_in};
        end
    end

    assign wr_pulse = wr_sync_q[1] & ~wr_sync_q[2];

    logic [7:0] ctrl_q [NUM_REGS];
    logic       wr_strobe_q;
    logic [7:0] wr_addr_q;
    logic       reg_hit;

    assign reg_hit = (address_in >= REG_BASE) && (address_in <= REG_LAST);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ctrl_q[i] <= 8'h00;
            end
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
        end else begin
            wr_strobe_q <= wr_pulse & reg_hit;
            if (wr_pulse && reg_hit) begin
                wr_addr_q <= address_in;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_pulse && (address_in == 8'(16 + i))) begin
                    ctrl_q[i] <= wr_data_in;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl_out
        assign ctrl_regs_out[8*g +: 8] = ctrl_q[g];
    end

    assign wr_strobe_out = wr_strobe_q;
    assign wr_addr_out   = wr_addr_q;

    logic [7:0] level_byte;
    logic [7:0] status_byte;
    logic [7:0] head_byte;

`ifdef SPI_REG_RXFIFO_EN
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [2:0]  rd_sync_q;
    logic        rd_pulse;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        underflow_q, underflow_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] level;
    logic [15:0] level_wide;
    logic        empty, full, push, pop;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            rd_sync_q <= 3'b111;
        end else begin
            rd_sync_q <= {rd_sync_q[1:0], data_rd_en_in};
        end
    end

    assign rd_pulse   = rd_sync_q[1] & ~rd_sync_q[2];
    assign level      = wr_ptr_q - rd_ptr_q;
    assign level_wide = 16'(level);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = fifo_valid_in & ~full;
    assign pop        = rd_pulse && (address_in == 8'h04);

    // Push and pop both judge the pre-cycle state; a pop on empty only flags underflow.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        underflow_d = underflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (pop && empty) begin
            underflow_d = 1'b1;
        end else if (wr_pulse && (address_in == 8'h03) && wr_data_in[2]) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock_in) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= fifo_data_in;
        end
    end

    assign fifo_ready_out = ~full;
    assign level_byte     = (level_wide > 16'd255) ? 8'hFF : level_wide[7:0];
    assign status_byte    = {5'b00000, underflow_q, full, empty};
    assign head_byte      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
`else
    logic unused_fifo;

    assign unused_fifo    = &{1'b0, fifo_data_in, fifo_valid_in, data_rd_en_in};
    assign fifo_ready_out = 1'b0;
    assign level_byte     = 8'h00;
    assign status_byte    = 8'h00;
    assign head_byte      = 8'h00;
`endif

    always_comb begin
        case (address_in)
            8'h00:   rd_data_out = CHIP_ID;
            8'h01:   rd_data_out = status_in;
            8'h02:   rd_data_out = level_byte;
            8'h03:   rd_data_out = status_byte;
            8'h04:   rd_data_out = head_byte;
            default: rd_data_out = 8'h00;
        endcase
        for (int i = 0; i < NUM_REGS; i++) begin
            if (address_in == 8'(16 + i)) begin
                rd_data_out = ctrl_q[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank; follows SPI_REG_RXFIFO_EN to pick FIFO or no-FIFO expectations.
module tb_spi_register_bank;

    logic        clock_in;
    logic        reset_in;
    logic [7:0]  address_in;
    logic [7:0]  wr_data_in;
    logic        data_wr_en_in;
    logic        data_rd_en_in;
    logic [7:0]  rd_data_out;
    logic [7:0]  status_in;
    logic [63:0] ctrl_regs_out;
    logic        wr_strobe_out;
    logic [7:0]  wr_addr_out;
    logic [7:0]  fifo_data_in;
    logic        fifo_valid_in;
    logic        fifo_ready_out;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;

    spi_register_bank #(
        .CHIP_ID   (8'hA5),
        .NUM_REGS  (8),
        .FIFO_DEPTH(16)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .address_in    (address_in),
        .wr_data_in    (wr_data_in),
        .data_wr_en_in (data_wr_en_in),
        .data_rd_en_in (data_rd_en_in),
        .rd_data_out   (rd_data_out),
        .status_in     (status_in),
        .ctrl_regs_out (ctrl_regs_out),
        .wr_strobe_out (wr_strobe_out),
        .wr_addr_out   (wr_addr_out),
        .fifo_data_in  (fifo_data_in),
        .fifo_valid_in (fifo_valid_in),
        .fifo_ready_out(fifo_ready_out)
    );

    // clock_in period 10 ns; SPI strobes are held 8 clocks (clock_in = 8x SPI clock).
    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    always @(posedge clock_in) begin
        if (wr_strobe_out === 1'b1) strobe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        address_in = addr;
        #1;
        check(tag, {56'h0, rd_data_out}, {56'h0, exp});
    endtask

    task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
        address_in    = addr;
        wr_data_in    = data;
        data_wr_en_in = 1'b1;
        tick(8);
        data_wr_en_in = 1'b0;
        tick(8);
    endtask

    // Read-consumed strobe; optionally pushes in the exact cycle the pop takes effect.
    task automatic spi_rd(input logic [7:0] addr, input bit with_push, input logic [7:0] pdata);
        address_in    = addr;
        data_rd_en_in = 1'b1;
        tick(2);
        if (with_push) begin
            fifo_data_in  = pdata;
            fifo_valid_in = 1'b1;
            tick(1);
            fifo_valid_in = 1'b0;
            tick(5);
        end else begin
            tick(6);
        end
        data_rd_en_in = 1'b0;
        tick(8);
    endtask

    task automatic push(input logic [7:0] d);
        fifo_data_in  = d;
        fifo_valid_in = 1'b1;
        tick(1);
        fifo_valid_in = 1'b0;
    endtask

    initial begin
        reset_in      = 1'b1;
        address_in    = 8'h00;
        wr_data_in    = 8'h00;
        data_wr_en_in = 1'b0;
        data_rd_en_in = 1'b0;
        status_in     = 8'h3C;
        fifo_data_in  = 8'h00;
        fifo_valid_in = 1'b0;
        tick(3);
        check("reset_ctrl", ctrl_regs_out, 64'h0);
        check("reset_strobe", {63'h0, wr_strobe_out}, 64'h0);
        check("reset_waddr", {56'h0, wr_addr_out}, 64'h0);
`ifdef SPI_REG_RXFIFO_EN
        check("reset_ready", {63'h0, fifo_ready_out}, 64'h1);
`else
        check("reset_ready", {63'h0, fifo_ready_out}, 64'h0);
`endif
        reset_in = 1'b0;
        tick(2);
        check_rd("rd_chip_id", 8'h00, 8'hA5);
        check_rd("rd_status", 8'h01, 8'h3C);
        check_rd("rd_unmapped", 8'h20, 8'h00);

        // Single write to 0x12: register visible by the third edge after the strobe rises
        address_in    = 8'h12;
        wr_data_in    = 8'h5A;
        data_wr_en_in = 1'b1;
        tick(3);
        check("wr_reg2_latency", ctrl_regs_out, 64'h0000_0000_005A_0000);
        check("wr_strobe_high", {63'h0, wr_strobe_out}, 64'h1);
        check("wr_addr_12", {56'h0, wr_addr_out}, 64'h12);
        check_rd("rd_reg2", 8'h12, 8'h5A);
        tick(1);
        check("wr_strobe_one_cycle", {63'h0, wr_strobe_out}, 64'h0);
        tick(4);
        data_wr_en_in = 1'b0;
        tick(8);
        check("strobe_cnt_1", strobe_cnt, 1);

        spi_write(8'h17, 8'h77);
        spi_write(8'h18, 8'h99);
        spi_write(8'h03, 8'h04);
        spi_write(8'h05, 8'hFF);
        check("ctrl_after_edges", ctrl_regs_out, 64'h7700_0000_005A_0000);
        check("strobe_cnt_2", strobe_cnt, 2);
        check("wr_addr_17", {56'h0, wr_addr_out}, 64'h17);
        check_rd("rd_reg7", 8'h17, 8'h77);

`ifdef SPI_REG_RXFIFO_EN
        check_rd("fifo_level_0", 8'h02, 8'h00);
        check_rd("fifo_stat_empty", 8'h03, 8'h01);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check_rd("fifo_level_3", 8'h02, 8'h03);
        check_rd("fifo_stat_3", 8'h03, 8'h00);
        check_rd("burst_head_0", 8'h04, 8'h11);
        spi_rd(8'h04, 1'b0, 8'h00);
        check_rd("burst_head_1", 8'h04, 8'h22);
        check_rd("burst_level_2", 8'h02, 8'h02);
        spi_rd(8'h04, 1'b0, 8'h00);
        check_rd("burst_head_2", 8'h04, 8'h33);
        spi_rd(8'h04, 1'b0, 8'h00);
        check_rd("burst_level_0", 8'h02, 8'h00);
        check_rd("burst_head_empty", 8'h04, 8'h00);
        check_rd("burst_stat_empty", 8'h03, 8'h01);
        spi_rd(8'h04, 1'b0, 8'h00);
        check_rd("underflow_head", 8'h04, 8'h00);
        check_rd("underflow_level", 8'h02, 8'h00);
        check_rd("underflow_stat", 8'h03, 8'h05);
        spi_write(8'h03, 8'h04);
        check_rd("underflow_clear", 8'h03, 8'h01);
        check("strobe_cnt_no_03", strobe_cnt, 2);

        // Push and pop in the same cycle on an empty FIFO
        spi_rd(8'h04, 1'b1, 8'h44);
        check_rd("simul_empty_level", 8'h02, 8'h01);
        check_rd("simul_empty_stat", 8'h03, 8'h04);
        check_rd("simul_empty_head", 8'h04, 8'h44);
        spi_write(8'h03, 8'h04);
        check_rd("simul_clear_stat", 8'h03, 8'h00);
        spi_rd(8'h02, 1'b0, 8'h00);
        check_rd("rd_other_addr_level", 8'h02, 8'h01);
        spi_rd(8'h04, 1'b1, 8'h55);
        check_rd("simul_full_level", 8'h02, 8'h01);
        check_rd("simul_full_head", 8'h04, 8'h55);
        spi_rd(8'h04, 1'b0, 8'h00);
        check_rd("drain_stat", 8'h03, 8'h01);

        for (int i = 0; i < 16; i++) push(8'(i * 3 + 1));
        check("full_ready", {63'h0, fifo_ready_out}, 64'h0);
        check_rd("full_stat", 8'h03, 8'h02);
        check_rd("full_level", 8'h02, 8'h10);
        push(8'hEE);
        check_rd("full_push_ignored", 8'h02, 8'h10);
        check_rd("full_head", 8'h04, 8'h01);
        fifo_data_in  = 8'hEE;
        fifo_valid_in = 1'b1;
        spi_rd(8'h04, 1'b0, 8'h00);
        fifo_valid_in = 1'b0;
        check_rd("full_pushpop_level", 8'h02, 8'h10);
        check("full_pushpop_ready", {63'h0, fifo_ready_out}, 64'h0);
        for (int i = 1; i < 17; i++) begin
            check_rd($sformatf("drain_%0d", i), 8'h04, (i == 16) ? 8'hEE : 8'(i * 3 + 1));
            spi_rd(8'h04, 1'b0, 8'h00);
        end
        check_rd("drain_done_stat", 8'h03, 8'h01);
        push(8'h66);
        check_rd("pre_reset_level", 8'h02, 8'h01);
`else
        push(8'h11);
        check("nofifo_ready", {63'h0, fifo_ready_out}, 64'h0);
        check_rd("nofifo_level", 8'h02, 8'h00);
        check_rd("nofifo_stat", 8'h03, 8'h00);
        check_rd("nofifo_head", 8'h04, 8'h00);
        spi_rd(8'h04, 1'b0, 8'h00);
        check_rd("nofifo_after_pop", 8'h03, 8'h00);
`endif

        // Complete one byte of a burst, then reset during the second byte's strobe
        address_in    = 8'h11;
        wr_data_in    = 8'hC3;
        data_wr_en_in = 1'b1;
        tick(8);
        data_wr_en_in = 1'b0;
        tick(8);
        check("burst_byte1", ctrl_regs_out, 64'h7700_0000_005A_C300);
        check("strobe_cnt_3", strobe_cnt, 3);
        wr_data_in    = 8'h3C;
        data_wr_en_in = 1'b1;
        tick(1);
        reset_in = 1'b1;
        tick(2);
        reset_in = 1'b0;
        tick(6);
        data_wr_en_in = 1'b0;
        tick(8);
        check("midreset_ctrl", ctrl_regs_out, 64'h0);
        check("midreset_strobe_cnt", strobe_cnt, 3);
        check("midreset_waddr", {56'h0, wr_addr_out}, 64'h0);
`ifdef SPI_REG_RXFIFO_EN
        check_rd("midreset_level", 8'h02, 8'h00);
        check_rd("midreset_stat", 8'h03, 8'h01);
        check("midreset_ready", {63'h0, fifo_ready_out}, 64'h1);
`else
        check("midreset_ready", {63'h0, fifo_ready_out}, 64'h0);
`endif
        spi_write(8'h10, 8'h21);
        check("post_reset_write", ctrl_regs_out, 64'h21);
        check("strobe_cnt_4", strobe_cnt, 4);
        check("post_reset_waddr", {56'h0, wr_addr_out}, 64'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
